// File: rtl/ledd_pkg.sv
// Shared constants for the service LED PWM block: LEDDCR0 bit positions,
// breathe-control layout, FSM encoding and parameter defaults.
package ledd_pkg;

    localparam int unsigned PwmwDefault   = 8;
    localparam int unsigned BlkmulDefault = 32;

    // LEDDCR0 bit positions
    localparam int unsigned Cr0Ledden    = 7;
    localparam int unsigned Cr0Outpol    = 5;
    localparam int unsigned Cr0QuickStop = 3;

    // Breathe control register bit positions (LEDDBCRR / LEDDBCFR)
    localparam int unsigned BcEnable = 7;

    // FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOn   = 2'd1;
    localparam logic [1:0] StOff  = 2'd2;
    localparam logic [1:0] StStop = 2'd3;

    typedef struct packed {
        logic       en;
        logic [3:0] rate;
    } breath_cfg_t;

endpackage

// File: rtl/ledd_pwm_if.sv
// Configuration register bundle from the LED control-bus register file.
interface ledd_pwm_if #(
    parameter int unsigned PWMW = 8
);
    logic [7:0]      leddcr0;
    logic [7:0]      leddbr;
    logic [7:0]      leddonr;
    logic [7:0]      leddofr;
    logic [7:0]      leddbcrr;
    logic [7:0]      leddbcfr;
    logic [PWMW-1:0] leddpwrr;
    logic [PWMW-1:0] leddpwgr;
    logic [PWMW-1:0] leddpwbr;

    modport master (
        output leddcr0, leddbr, leddonr, leddofr, leddbcrr, leddbcfr,
        output leddpwrr, leddpwgr, leddpwbr
    );

    modport slave (
        input leddcr0, leddbr, leddonr, leddofr, leddbcrr, leddbcfr,
        input leddpwrr, leddpwgr, leddpwbr
    );
endinterface

// File: rtl/ledd_pwm_chan.sv
// One PWM colour channel: duty shadow, breath scaling, compare and
// polarity-corrected output flop.
module ledd_pwm_chan #(
    parameter int unsigned PWMW = 8
) (
    input  logic            ledd_clk,
    input  logic            ledd_rst_async,
    input  logic            load_i,
    input  logic [PWMW-1:0] duty_i,
    input  logic [7:0]      scl_i,
    input  logic [PWMW-1:0] cnt_i,
    input  logic            act_i,
    input  logic            pol_i,
    output logic            pwm_o
);
    localparam int unsigned ProdW = PWMW + 9;

    logic [PWMW-1:0]  duty_q;
    logic [8:0]       scl_p1;
    logic [ProdW-1:0] prod;
    logic [PWMW-1:0]  eff;
    logic             pwm_d;
    logic             pwm_q;
    logic             unused_prod;

    // w * (scl + 1) >> 8, so scl = 255 leaves the duty untouched
    assign scl_p1      = {1'b0, scl_i} + 9'd1;
    assign prod        = ProdW'(duty_q) * ProdW'(scl_p1);
    assign eff         = prod[PWMW+7:8];
    assign unused_prod = ^{prod[ProdW-1], prod[7:0]};

    // Next output level: compare against the scaled duty, then apply polarity
    always_comb begin
        pwm_d = ((cnt_i < eff) & act_i) ^ pol_i;
    end

    // Duty shadow: only updated at period boundaries so the waveform never glitches
    always_ff @(posedge ledd_clk or posedge ledd_rst_async) begin
        if (ledd_rst_async) begin
            duty_q <= '0;
        end else if (load_i) begin
            duty_q <= duty_i;
        end
    end

    // Registered output
    always_ff @(posedge ledd_clk or posedge ledd_rst_async) begin
        if (ledd_rst_async) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/ledd_pwm.sv
// LED PWM generator: prescaler, PWM counter, ON/OFF blink sequencer and
// breathe ramp driving three colour channels.
module ledd_pwm
    import ledd_pkg::*;
#(
    parameter int unsigned PWMW   = PwmwDefault,
    parameter int unsigned BLKMUL = BlkmulDefault
) (
    input  logic      ledd_clk,
    input  logic      ledd_rst_async,
    ledd_pwm_if.slave cfg,
    output logic      pwm_out_r,
    output logic      pwm_out_g,
    output logic      pwm_out_b,
    output logic      ledd_on
);
    logic        en;
    logic        pol;
    logic        qstop;
    logic [9:0]  pre;
    breath_cfg_t bon_live;
    breath_cfg_t bof_live;
    logic        unused_cfg;

    assign en       = cfg.leddcr0[Cr0Ledden];
    assign pol      = cfg.leddcr0[Cr0Outpol];
    assign qstop    = cfg.leddcr0[Cr0QuickStop];
    assign pre      = {cfg.leddcr0[1:0], cfg.leddbr};
    assign bon_live = '{en: cfg.leddbcrr[BcEnable], rate: cfg.leddbcrr[3:0]};
    assign bof_live = '{en: cfg.leddbcfr[BcEnable], rate: cfg.leddbcfr[3:0]};
    assign unused_cfg = ^{cfg.leddcr0[6], cfg.leddcr0[4], cfg.leddcr0[2],
                          cfg.leddbcrr[6:4], cfg.leddbcfr[6:4]};

    logic [1:0]      state_q, state_d;
    logic [9:0]      pre_q, pre_d;
    logic [PWMW-1:0] cnt_q, cnt_d;
    logic [12:0]     blink_q, blink_d, blink_nx;
    logic [3:0]      brc_q, brc_d;
    logic [7:0]      scl_q, scl_d;
    logic [7:0]      on_q, off_q;
    breath_cfg_t     bon_q, bof_q;
    logic            ledd_on_q;

    logic        tick;
    logic        pend;
    logic        load;
    logic        chan_act;
    logic [3:0]  rate;
    logic [31:0] on_lim;
    logic [31:0] off_lim;

    // Compare with >= so a mid-run drop of the prescale value cannot stall the counter
    assign tick     = (pre_q >= pre);
    assign pend     = tick && (cnt_q == '1) && (state_q != StIdle);
    assign blink_nx = (blink_q == '1) ? blink_q : blink_q + 13'd1;
    assign on_lim   = 32'(on_q) * BLKMUL;
    assign off_lim  = 32'(off_q) * BLKMUL;
    assign rate     = (state_q == StOff) ? bof_q.rate : bon_q.rate;

    // During OFF the LED keeps glowing only while a breathe-off ramp is still above zero
    assign chan_act = (state_q == StOn) || (state_q == StStop) ||
                      ((state_q == StOff) && bof_q.en && (scl_q != 8'd0));

    // Sequencer: counters, breath ramp and phase transitions
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        brc_d   = brc_q;
        scl_d   = scl_q;
        load    = 1'b0;

        if (state_q != StIdle) begin
            pre_d = tick ? 10'd0 : pre_q + 10'd1;
            if (tick) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (pend) begin
            load    = 1'b1;
            blink_d = blink_nx;
            if (brc_q >= rate) begin
                brc_d = 4'd0;
                if ((state_q == StOn) && bon_q.en && (scl_q != 8'hFF)) begin
                    scl_d = scl_q + 8'd1;
                end
                if ((state_q == StOff) && bof_q.en && (scl_q != 8'h00)) begin
                    scl_d = scl_q - 8'd1;
                end
            end else begin
                brc_d = brc_q + 4'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StOn;
                    load    = 1'b1;
                    pre_d   = 10'd0;
                    cnt_d   = '0;
                    blink_d = 13'd0;
                    brc_d   = 4'd0;
                    scl_d   = bon_live.en ? 8'h00 : 8'hFF;
                end
            end
            StOn: begin
                // A stop always wins over a blink phase change in the same cycle
                if (!en) begin
                    state_d = qstop ? StIdle : StStop;
                end else if (pend && (off_q != 8'd0) && (32'(blink_nx) >= on_lim)) begin
                    state_d = StOff;
                    blink_d = 13'd0;
                    brc_d   = 4'd0;
                end
            end
            StOff: begin
                if (!en) begin
                    state_d = qstop ? StIdle : StStop;
                end else if (pend && (on_q != 8'd0) && (32'(blink_nx) >= off_lim)) begin
                    state_d = StOn;
                    blink_d = 13'd0;
                    brc_d   = 4'd0;
                    scl_d   = bon_live.en ? 8'h00 : 8'hFF;
                end
            end
            StStop: begin
                if ((!en && qstop) || pend) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state
    always_ff @(posedge ledd_clk or posedge ledd_rst_async) begin
        if (ledd_rst_async) begin
            state_q   <= StIdle;
            pre_q     <= 10'd0;
            cnt_q     <= '0;
            blink_q   <= 13'd0;
            brc_q     <= 4'd0;
            scl_q     <= 8'd0;
            ledd_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            brc_q     <= brc_d;
            scl_q     <= scl_d;
            ledd_on_q <= (state_d == StOn);
        end
    end

    // Blink and breathe shadows, captured with the duty shadows
    always_ff @(posedge ledd_clk or posedge ledd_rst_async) begin
        if (ledd_rst_async) begin
            on_q  <= 8'd0;
            off_q <= 8'd0;
            bon_q <= '0;
            bof_q <= '0;
        end else if (load) begin
            on_q  <= cfg.leddonr;
            off_q <= cfg.leddofr;
            bon_q <= bon_live;
            bof_q <= bof_live;
        end
    end

    assign ledd_on = ledd_on_q;

    ledd_pwm_chan #(.PWMW(PWMW)) u_chan_r (
        .ledd_clk       (ledd_clk),
        .ledd_rst_async (ledd_rst_async),
        .load_i         (load),
        .duty_i         (cfg.leddpwrr),
        .scl_i          (scl_q),
        .cnt_i          (cnt_q),
        .act_i          (chan_act),
        .pol_i          (pol),
        .pwm_o          (pwm_out_r)
    );

    ledd_pwm_chan #(.PWMW(PWMW)) u_chan_g (
        .ledd_clk       (ledd_clk),
        .ledd_rst_async (ledd_rst_async),
        .load_i         (load),
        .duty_i         (cfg.leddpwgr),
        .scl_i          (scl_q),
        .cnt_i          (cnt_q),
        .act_i          (chan_act),
        .pol_i          (pol),
        .pwm_o          (pwm_out_g)
    );

    ledd_pwm_chan #(.PWMW(PWMW)) u_chan_b (
        .ledd_clk       (ledd_clk),
        .ledd_rst_async (ledd_rst_async),
        .load_i         (load),
        .duty_i         (cfg.leddpwbr),
        .scl_i          (scl_q),
        .cnt_i          (cnt_q),
        .act_i          (chan_act),
        .pol_i          (pol),
        .pwm_o          (pwm_out_b)
    );

endmodule

// File: tb/tb_ledd_pwm.sv
// Directed bench for the LED PWM generator.
module tb_ledd_pwm;
    logic ledd_clk = 1'b0;
    logic rst;
    logic pwm_r, pwm_g, pwm_b, led_on;
    int   n_chk = 0;
    int   n_err = 0;

    ledd_pwm_if #(.PWMW(8)) bus ();

    ledd_pwm #(.PWMW(8), .BLKMUL(32)) dut (
        .ledd_clk       (ledd_clk),
        .ledd_rst_async (rst),
        .cfg            (bus),
        .pwm_out_r      (pwm_r),
        .pwm_out_g      (pwm_g),
        .pwm_out_b      (pwm_b),
        .ledd_on        (led_on)
    );

    always #5 ledd_clk = ~ledd_clk;

    // Advance n clocks and land 1 ns after the edge
    task automatic tick_n(input int n);
        repeat (n) @(posedge ledd_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] cr0, input logic [7:0] br, input logic [7:0] onr,
                           input logic [7:0] ofr, input logic [7:0] bcr, input logic [7:0] bcf,
                           input logic [7:0] wr, input logic [7:0] wg, input logic [7:0] wb);
        bus.leddcr0  = cr0;
        bus.leddbr   = br;
        bus.leddonr  = onr;
        bus.leddofr  = ofr;
        bus.leddbcrr = bcr;
        bus.leddbcfr = bcf;
        bus.leddpwrr = wr;
        bus.leddpwgr = wg;
        bus.leddpwbr = wb;
    endtask

    task automatic go_idle();
        bus.leddcr0 = 8'h08;
        tick_n(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick_n(2);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 0000", {pwm_r, pwm_g, pwm_b, led_on});
        end
        bus.leddcr0 = 8'h20;
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: got %b want 0000", {pwm_r, pwm_g, pwm_b, led_on});
        end
        rst = 1'b0;
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b1110) begin
            n_err++;
            $display("FAIL idle_pol1: got %b want 1110", {pwm_r, pwm_g, pwm_b, led_on});
        end
        bus.leddcr0 = 8'h00;
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_pol0: got %b want 0000", {pwm_r, pwm_g, pwm_b, led_on});
        end
    endtask

    task automatic test_basic();
        int   hr1 = 0, hg1 = 0, hb1 = 0, hr2 = 0, on_low = 0;
        logic r_first = 1'b0;
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'd64, 8'd0, 8'd255);
        tick_n(1);
        n_chk++;
        if (pwm_r !== 1'b0) begin
            n_err++;
            $display("FAIL basic_latency: got %b want 0", pwm_r);
        end
        n_chk++;
        if (led_on !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ledd_on: got %b want 1", led_on);
        end
        for (int k = 2; k <= 513; k++) begin
            tick_n(1);
            if (k == 2) r_first = pwm_r;
            if (k <= 257) begin
                hr1 += int'(pwm_r);
                hg1 += int'(pwm_g);
                hb1 += int'(pwm_b);
            end else begin
                hr2 += int'(pwm_r);
            end
            if (!led_on) on_low++;
        end
        n_chk++;
        if (r_first !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first_active: got %b want 1", r_first);
        end
        n_chk++;
        if (hr1 !== 64) begin
            n_err++;
            $display("FAIL basic_r_p1: got %0d want 64", hr1);
        end
        n_chk++;
        if (hr2 !== 64) begin
            n_err++;
            $display("FAIL basic_r_p2: got %0d want 64", hr2);
        end
        n_chk++;
        if (hg1 !== 0) begin
            n_err++;
            $display("FAIL basic_g_w0: got %0d want 0", hg1);
        end
        n_chk++;
        if (hb1 !== 255) begin
            n_err++;
            $display("FAIL basic_b_w255: got %0d want 255", hb1);
        end
        n_chk++;
        if (on_low !== 0) begin
            n_err++;
            $display("FAIL basic_on_steady: got %0d low cycles want 0", on_low);
        end
    endtask

    task automatic test_quick_stop();
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'd64, 8'd0, 8'd255);
        tick_n(20);
        n_chk++;
        if ({pwm_r, pwm_b} !== 2'b11) begin
            n_err++;
            $display("FAIL qstop_pre: got %b want 11", {pwm_r, pwm_b});
        end
        bus.leddcr0 = 8'h08;
        tick_n(1);
        n_chk++;
        if (led_on !== 1'b0) begin
            n_err++;
            $display("FAIL qstop_on: got %b want 0", led_on);
        end
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_b} !== 2'b00) begin
            n_err++;
            $display("FAIL qstop_outs: got %b want 00", {pwm_r, pwm_b});
        end
    endtask

    task automatic test_slow_stop();
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'd64, 8'd0, 8'd255);
        tick_n(11);
        bus.leddcr0 = 8'h00;
        tick_n(1);
        n_chk++;
        if (led_on !== 1'b0) begin
            n_err++;
            $display("FAIL sstop_on: got %b want 0", led_on);
        end
        tick_n(28);
        n_chk++;
        if (pwm_r !== 1'b1) begin
            n_err++;
            $display("FAIL sstop_running: got %b want 1", pwm_r);
        end
        tick_n(216);
        n_chk++;
        if (pwm_b !== 1'b1) begin
            n_err++;
            $display("FAIL sstop_b_254: got %b want 1", pwm_b);
        end
        tick_n(2);
        n_chk++;
        if (pwm_b !== 1'b0) begin
            n_err++;
            $display("FAIL sstop_idle_at_pend: got %b want 0", pwm_b);
        end
        tick_n(40);
        n_chk++;
        if ({pwm_r, pwm_b} !== 2'b00) begin
            n_err++;
            $display("FAIL sstop_idle_hold: got %b want 00", {pwm_r, pwm_b});
        end
    endtask

    task automatic test_mid_write_polarity();
        int hr1 = 0, hr2 = 0, ir = 0, ig = 0, ib = 0;
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'd64, 8'd0, 8'd255);
        tick_n(1);
        for (int k = 2; k <= 513; k++) begin
            tick_n(1);
            if (k <= 257) hr1 += int'(pwm_r);
            else hr2 += int'(pwm_r);
            if (k == 11) bus.leddpwrr = 8'd128;
        end
        n_chk++;
        if (hr1 !== 64) begin
            n_err++;
            $display("FAIL midwr_old_period: got %0d want 64", hr1);
        end
        n_chk++;
        if (hr2 !== 128) begin
            n_err++;
            $display("FAIL midwr_new_period: got %0d want 128", hr2);
        end
        bus.leddcr0 = 8'hA0;
        for (int k = 514; k <= 769; k++) begin
            tick_n(1);
            ir += int'(pwm_r);
            ig += int'(pwm_g);
            ib += int'(pwm_b);
        end
        n_chk++;
        if ({ir, ig, ib} !== {32'd128, 32'd256, 32'd1}) begin
            n_err++;
            $display("FAIL pol_inv: got r=%0d g=%0d b=%0d want r=128 g=256 b=1", ir, ig, ib);
        end
        bus.leddcr0 = 8'h28;
        tick_n(2);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b1110) begin
            n_err++;
            $display("FAIL pol_idle: got %b want 1110", {pwm_r, pwm_g, pwm_b, led_on});
        end
        bus.leddcr0 = 8'h00;
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
            n_err++;
            $display("FAIL pol_idle_track: got %b want 000", {pwm_r, pwm_g, pwm_b});
        end
    endtask

    task automatic test_prescale();
        go_idle();
        // pre = 259: cnt steps every 260 clocks, so duty 2 spans 520 clocks
        set_cfg(8'h81, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'd2, 8'd0, 8'd0);
        tick_n(2);
        n_chk++;
        if (pwm_r !== 1'b1) begin
            n_err++;
            $display("FAIL pre_start: got %b want 1", pwm_r);
        end
        tick_n(519);
        n_chk++;
        if (pwm_r !== 1'b1) begin
            n_err++;
            $display("FAIL pre_last_high: got %b want 1", pwm_r);
        end
        tick_n(1);
        n_chk++;
        if (pwm_r !== 1'b0) begin
            n_err++;
            $display("FAIL pre_first_low: got %b want 0", pwm_r);
        end
    endtask

    task automatic test_blink();
        int   on_hi = 0, off_hi = 0, on_zero = 0, off_one = 0;
        logic on_back = 1'b0;
        logic r_back  = 1'b0;
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'd64, 8'd0, 8'd0);
        tick_n(1);
        for (int k = 2; k <= 24578; k++) begin
            tick_n(1);
            if (k <= 16385) on_hi += int'(pwm_r);
            else if (k <= 24577) off_hi += int'(pwm_r);
            if (k <= 16384 && !led_on) on_zero++;
            if (k >= 16385 && k <= 24576 && led_on) off_one++;
            if (k == 24577) on_back = led_on;
            if (k == 24578) r_back = pwm_r;
        end
        n_chk++;
        if (on_hi !== 4096) begin
            n_err++;
            $display("FAIL blink_on_active: got %0d want 4096", on_hi);
        end
        n_chk++;
        if (off_hi !== 0) begin
            n_err++;
            $display("FAIL blink_off_active: got %0d want 0", off_hi);
        end
        n_chk++;
        if (on_zero !== 0) begin
            n_err++;
            $display("FAIL blink_on_flag: got %0d low want 0", on_zero);
        end
        n_chk++;
        if (off_one !== 0) begin
            n_err++;
            $display("FAIL blink_off_flag: got %0d high want 0", off_one);
        end
        n_chk++;
        if ({on_back, r_back} !== 2'b11) begin
            n_err++;
            $display("FAIL blink_reenter_on: got %b want 11", {on_back, r_back});
        end
    endtask

    task automatic test_breathe();
        int h;
        go_idle();
        // Rate 0, w = 255: period p runs at scl = p, so duty (255*(p+1))>>8 = p
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'd255, 8'd0, 8'd0);
        tick_n(1);
        for (int p = 0; p < 32; p++) begin
            h = 0;
            for (int k = 0; k < 256; k++) begin
                tick_n(1);
                h += int'(pwm_r);
            end
            n_chk++;
            if (h !== p) begin
                n_err++;
                $display("FAIL breathe_p%0d: got %0d want %0d", p, h, p);
            end
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        set_cfg(8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'd255, 8'd255, 8'd255);
        tick_n(5);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b1111) begin
            n_err++;
            $display("FAIL rstmid_pre: got %b want 1111", {pwm_r, pwm_g, pwm_b, led_on});
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_async: got %b want 0000", {pwm_r, pwm_g, pwm_b, led_on});
        end
        bus.leddcr0 = 8'h00;
        tick_n(2);
        rst = 1'b0;
        tick_n(1);
        n_chk++;
        if ({pwm_r, pwm_g, pwm_b, led_on} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_after: got %b want 0000", {pwm_r, pwm_g, pwm_b, led_on});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quick_stop();
        test_slow_stop();
        test_mid_write_polarity();
        test_prescale();
        test_blink();
        test_breathe();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
